mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the EX-stage ALU, executing MULT, MULTU, DIV and DIVU.
//  Iterative shift-add multiply and restoring divide over WIDTH cycles; results go to architectural HI/LO.
//  Holds busy so hazard logic stalls MFHI/MFLO and any new mult/div until the result is committed.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request: op/a/b valid this cycle
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a       in   WIDTH  rs operand (multiplicand / dividend)
//  b       in   WIDTH  rt operand (multiplier / divisor)
//  flush   in   1      pipeline squash: abort in-flight operation
//  busy    out  1      operation in flight; start ignored while high
//  done    out  1      one-cycle pulse: HI/LO updated this cycle
//  hi      out  WIDTH  HI register (product high / remainder)
//  lo      out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal regs cleared.
//  States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 and flush=0 -> latch |a|, |b| (signed ops) or raw (unsigned), record sign_a/sign_b
//         and op, counter=WIDTH-1, go to CALC. busy=1 from the next cycle.
//   CALC: one iteration per cycle; counter decrements; at counter==0 go to FIX.
//         mult: 2*WIDTH accumulator, add multiplicand if LSB of multiplier, shift right.
//         div : shift remainder:quotient left, trial subtract divisor, keep if non-negative, set qbit.
//   FIX : sign correction (2's complement negate), write hi/lo, done=1 next cycle, return to IDLE.
//         MULT: negate 2*WIDTH product if sign_a^sign_b. DIV: quotient negated if sign_a^sign_b,
//         remainder negated if sign_a (remainder takes dividend's sign).
//  Latency: start accepted at edge k -> busy=1 cycles k+1..k+WIDTH+1; hi/lo and done=1 at cycle
//           k+WIDTH+2 (34 for WIDTH=32); busy=0 in that cycle, so start may be accepted alongside done.
//  Divide by zero (b==0, DIV/DIVU): no iteration; IDLE -> FIX directly; hi=a, lo={WIDTH{1'b1}}.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of magnitude arithmetic, no trap).
//  Widths: magnitudes held as WIDTH-bit unsigned (|-2^(W-1)| fits); remainder WIDTH+1 bits for the
//          trial subtract; product 2*WIDTH bits.
//  flush: in CALC/FIX returns to IDLE next cycle, busy=0, done stays 0, hi/lo unchanged.
//         flush with start in IDLE: start dropped. flush wins over FIX commit in the same cycle.
//  start while busy=1: ignored, no effect on the operation in flight (hazard unit is responsible).
//  hi/lo change only on FIX commit or reset; they hold value at every other time.
// STRUCTURE
//  Shared package mips_pkg: MDU_MULT/MULTU/DIV/DIVU op encodings, mdu_state_t enum
//  {IDLE, CALC, FIX}, WIDTH default constant.
//  One natural sub-module: mdu_datapath (accumulator, shift/trial-subtract step, sign fix-up);
//  mdu_sequencer keeps FSM, counter, handshake and HI/LO registers.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at +34, hi=0xFFFFFFFE lo=0x00000001, busy high 33 cycles.
//  MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIVU 7/2 -> lo=3 hi=1.
//  DIVU a=0x1234 b=0 -> done at +2, hi=0x1234 lo=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  Prior hi/lo=5/6; start MULT then flush at +10 -> busy=0 at +11, done never, hi/lo stay 5/6;
//  start at +5 during busy ignored.
//  rst pulsed mid-CALC (async, between edges) -> busy/done/hi/lo=0 immediately; start with done
//  (back-to-back) -> second op accepted.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: op encodings, FSM states and decode helpers.
package mips_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic opIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic opIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Datapath of the multiply/divide unit: operand magnitudes, one shift-add or restoring-divide
// iteration per step, and the final sign correction presented to the HI/LO registers.
module mdu_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_divZero,
    output logic [WIDTH-1:0] o_hiRes,
    output logic [WIDTH-1:0] o_loRes
);

    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_operand;
    logic               r_signA;
    logic               r_signB;
    logic               r_isDiv;
    logic               r_divZero;

    logic               w_signedOp;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shifted;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;

    // The magnitude of the most negative value still fits in WIDTH unsigned bits.
    assign w_signedOp = opIsSigned(i_op);
    assign w_signA    = w_signedOp & i_a[WIDTH-1];
    assign w_signB    = w_signedOp & i_b[WIDTH-1];
    assign w_magA     = w_signA ? -i_a : i_a;
    assign w_magB     = w_signB ? -i_b : i_b;
    assign o_divZero  = opIsDiv(i_op) && (i_b == '0);

    assign w_addend  = r_lower[0] ? r_operand : '0;
    assign w_sum     = {1'b0, r_upper} + {1'b0, w_addend};

    // Trial subtract only needs the carry-out bit of the shifted remainder for the compare.
    assign w_shifted = {r_upper, r_lower[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_operand});
    assign w_diff    = w_shifted[WIDTH-1:0] - r_operand;

    assign w_product = {r_upper, r_lower};
    assign w_prodFix = (r_signA ^ r_signB) ? -w_product : w_product;
    assign w_quotFix = (r_signA ^ r_signB) ? -r_lower : r_lower;
    assign w_remFix  = r_signA ? -r_upper : r_upper;

    always_comb begin
        o_hiRes = w_prodFix[2*WIDTH-1:WIDTH];
        o_loRes = w_prodFix[WIDTH-1:0];
        if (r_divZero) begin
            o_hiRes = r_lower;
            o_loRes = '1;
        end else if (r_isDiv) begin
            o_hiRes = w_remFix;
            o_loRes = w_quotFix;
        end
    end

    // Multiply keeps the multiplier in the low half; divide keeps the dividend there as it
    // shifts into the remainder and the quotient bits fill in from the bottom.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_upper   <= '0;
            r_lower   <= '0;
            r_operand <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
        end else if (i_load) begin
            r_upper   <= '0;
            r_signA   <= w_signA;
            r_signB   <= w_signB;
            r_isDiv   <= opIsDiv(i_op);
            r_divZero <= o_divZero;
            if (opIsDiv(i_op)) begin
                r_lower   <= o_divZero ? i_a : w_magA;
                r_operand <= w_magB;
            end else begin
                r_lower   <= w_magB;
                r_operand <= w_magA;
            end
        end else if (i_step) begin
            if (r_isDiv) begin
                r_upper <= w_fits ? w_diff : w_shifted[WIDTH-1:0];
                r_lower <= {r_lower[WIDTH-2:0], w_fits};
            end else begin
                r_upper <= w_sum[WIDTH:1];
                r_lower <= {w_sum[0], r_lower[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: FSM, iteration counter, busy/done handshake
// and the architectural HI/LO registers.
module mdu_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_t       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_divZero;
    logic [WIDTH-1:0] w_hiRes;
    logic [WIDTH-1:0] w_loRes;

    assign w_load = (r_state == IDLE) && i_start && !i_flush;
    assign w_step = (r_state == CALC) && !i_flush;

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    mdu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_divZero(w_divZero),
        .o_hiRes  (w_hiRes),
        .o_loRes  (w_loRes)
    );

    // Divide by zero skips CALC entirely; a flush in FIX beats the commit so HI/LO never see it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_count <= CW'(WIDTH - 1);
                        if (w_divZero) begin
                            r_state <= FIX;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else if (r_count == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!i_flush) begin
                        r_hi   <= w_hiRes;
                        r_lo   <= w_loRes;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random operations
// compared against a plain-arithmetic reference of MULT/MULTU/DIV/DIVU.
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(
        .WIDTH(W)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_op   (op),
        .i_a    (a),
        .i_b    (b),
        .i_flush(flush),
        .o_busy (busy),
        .o_done (done),
        .o_hi   (hi),
        .o_lo   (lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Returns {hi, lo} straight from the architectural definition of each instruction.
    function automatic logic [63:0] refModel(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        sa = $signed(ma);
        sb = $signed(mb);
        ua = {32'd0, ma};
        ub = {32'd0, mb};
        case (mop)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Presents one start request; returns one cycle after the accepting edge.
    task automatic applyStimulus(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        start = 1'b1;
        op    = mop;
        a     = ma;
        b     = mb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runOp(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb, input string tag);
        logic [63:0] expected;
        int          cyc;
        int          busyCycles;
        int          expLat;
        expected   = refModel(mop, ma, mb);
        expLat     = (mop[1] && mb == 32'd0) ? 2 : W + 2;
        applyStimulus(mop, ma, mb);
        cyc        = 1;
        busyCycles = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'(expLat - 1));
        checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
        checkOutput({tag, ".hi"}, 64'(hi), 64'(expected[63:32]));
        checkOutput({tag, ".lo"}, 64'(lo), 64'(expected[31:0]));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] lastExp;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int          doneSeen;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.hi", 64'(hi), 64'd0);
        checkOutput("reset.lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multuMax");
        runOp(2'b00, 32'hFFFF_FFFD, 32'd5, "multNeg");
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, "divNeg");
        runOp(2'b11, 32'd7, 32'd2, "divu7by2");
        runOp(2'b11, 32'h0000_1234, 32'd0, "divuByZero");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "divMinByNeg1");
        runOp(2'b10, 32'h0000_0055, 32'd0, "divByZero");
        runOp(2'b11, 32'd65, 32'd10, "primeHiLo");

        // Flush mid-CALC, with an ignored start while busy.
        applyStimulus(2'b00, 32'h0123_4567, 32'h0000_0089);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 2'b11;
        a     = 32'h0000_1234;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("flushCalc.busyBefore", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flushCalc.busyAfter", 64'(busy), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("flushCalc.noDone", 64'(doneSeen), 64'd0);
        checkOutput("flushCalc.hi", 64'(hi), 64'd5);
        checkOutput("flushCalc.lo", 64'(lo), 64'd6);

        // Start together with flush in IDLE is dropped.
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b11;
        a     = 32'd1;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flushIdle.busy", 64'(busy), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) doneSeen = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("flushIdle.noDone", 64'(doneSeen), 64'd0);

        // Flush arriving in the FIX cycle suppresses the commit.
        applyStimulus(2'b01, 32'd3, 32'd4);
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        checkOutput("flushFix.busyBefore", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flushFix.done", 64'(done), 64'd0);
        checkOutput("flushFix.busy", 64'(busy), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("flushFix.hi", 64'(hi), 64'd5);
        checkOutput("flushFix.lo", 64'(lo), 64'd6);

        // Asynchronous reset between edges while CALC is running.
        applyStimulus(2'b01, 32'd7, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.busy", 64'(busy), 64'd0);
        checkOutput("asyncRst.done", 64'(done), 64'd0);
        checkOutput("asyncRst.hi", 64'(hi), 64'd0);
        checkOutput("asyncRst.lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: each runOp starts in the cycle where the previous done is high.
        runOp(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, "b2bFirst");
        runOp(2'b11, 32'hDEAD_BEEF, 32'h0000_0100, "b2bSecond");

        lastExp = '0;
        for (int n = 0; n < 30; n++) begin
            rOp = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       rA = 32'h8000_0000;
                1:       rA = 32'($urandom_range(0, 15));
                default: rA = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rB = 32'd0;
                1:       rB = 32'hFFFF_FFFF;
                2:       rB = 32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            lastExp = refModel(rOp, rA, rB);
            runOp(rOp, rA, rB, $sformatf("rand%0d", n));
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("hold.done", 64'(done), 64'd0);
        checkOutput("hold.hi", 64'(hi), 64'(lastExp[63:32]));
        checkOutput("hold.lo", 64'(lo), 64'(lastExp[31:0]));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
